abuf2ddr: RTL and testbench

- Drain path for the accumulation buffer: reads one PE's accumulation data or tail entries and streams them to the DDR write channel as DDR_W-wide words with valid/ready handshake.
- Mirror of the DDR-to-buffer load path.
- Uses the same packing, so a load of a stored stream reproduces the buffer contents.
- Sits between the PE array's accumulation buffers (through an external PE read mux) and the DDR write stream.

---
 rtl/abuf2ddr_pkg.sv | 21 ++
 rtl/abuf2ddr_sync_fifo.sv | 60 ++++++
 rtl/abuf2ddr.sv | 170 +++++++++++++++++
 tb/tb_abuf2ddr.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/abuf2ddr_pkg.sv
// abuf2ddr_pkg: widths shared by the accumulation-buffer drain path,
// the bw() width helper and the drain FSM state type. No ports.
package abuf2ddr_pkg;

    localparam int DATA_W = 16;
    localparam int BATCH  = 4;
    localparam int DDR_W  = 64;
    localparam int TAIL_W = 32;

    // Bits needed to index n items; never less than one.
    function automatic int bw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/abuf2ddr_sync_fifo.sv
// abuf2ddr_sync_fifo: small synchronous FIFO holding returned buffer entries.
// Ports: clk/rst, push_i/wdata_i write side, pop_i read side,
// head_o oldest entry, next_o entry behind it, count_o occupancy.
module abuf2ddr_sync_fifo
    import abuf2ddr_pkg::*;
#(
    parameter int W     = 128,
    parameter int DEPTH = 4,
    parameter int CNT_W = bw(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     wdata_i,
    output logic [W-1:0]     head_o,
    output logic [W-1:0]     next_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = bw(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W-1:0] rd_nx;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_nx   = inc(rd_q);
    assign head_o  = mem_q[rd_q];
    // Lookahead lets the serialiser move to the next entry on the pop edge.
    assign next_o  = mem_q[rd_nx];
    assign count_o = cnt_q;

    // Caller never pushes when full nor pops when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= inc(wr_q);
            end
            if (pop_i) begin
                rd_q <= rd_nx;
            end
            cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

endmodule

// File: rtl/abuf2ddr.sv
// abuf2ddr: drains one PE accumulation buffer (data or tail entries) to
// the DDR write stream. Ports: start/done control, conf_* transfer setup,
// abuf_rd_* buffer read side, ddr_data/ddr_valid/ddr_ready output stream.
module abuf2ddr
    import abuf2ddr_pkg::*;
#(
    parameter int BUF_DEPTH  = 256,
    parameter int PE_NUM     = 32,
    parameter int ADDR_W     = bw(BUF_DEPTH),
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    done,
    input  logic                    conf_trans_type,
    input  logic [7:0]              conf_trans_num,
    input  logic [bw(PE_NUM)-1:0]   conf_pe_sel,
    output logic [bw(PE_NUM)-1:0]   abuf_rd_pe,
    output logic [ADDR_W-1:0]       abuf_rd_addr,
    output logic                    abuf_rd_en,
    input  logic [BATCH*DATA_W-1:0] abuf_rd_data,
    input  logic [BATCH*TAIL_W-1:0] abuf_rd_tail,
    output logic [DDR_W-1:0]        ddr_data,
    output logic                    ddr_valid,
    input  logic                    ddr_ready
);

    localparam int PE_W    = bw(PE_NUM);
    localparam int ENT_W   = BATCH * TAIL_W;
    localparam int TD_RATE = TAIL_W / DATA_W;
    localparam int SL_W    = bw(TD_RATE);
    localparam int CNT_W   = bw(FIFO_DEPTH + 1);
    localparam int OCC_W   = bw(FIFO_DEPTH + RD_LAT + 1) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              type_q;
    logic [7:0]        num_q;
    logic [PE_W-1:0]   pe_q;
    logic [RD_LAT-1:0] vld_q;
    logic [SL_W-1:0]   slice_q, slice_d;
    logic              dval_q, dval_d;
    logic [DDR_W-1:0]  ddata_q, ddata_d;

    logic              push, pop, hs, last_sl, rd_en;
    logic [ENT_W-1:0]  wdata, head, nxt;
    logic [CNT_W-1:0]  fcnt;
    logic [OCC_W-1:0]  inflight, occ;

    abuf2ddr_sync_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .head_o  (head),
        .next_o  (nxt),
        .count_o (fcnt)
    );

    // Credit: reads in flight plus stored entries bound what may be issued.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + OCC_W'(vld_q[i]);
        end
        occ = inflight + OCC_W'(fcnt);
    end

    assign push    = vld_q[RD_LAT-1];
    assign wdata   = type_q ? abuf_rd_tail : ENT_W'(abuf_rd_data);
    assign hs      = dval_q & ddr_ready;
    assign last_sl = ~type_q | (slice_q == SL_W'(TD_RATE - 1));
    // The entry stays in the FIFO until its last slice is accepted.
    assign pop     = hs & last_sl;

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                rd_en = (occ < OCC_W'(FIFO_DEPTH));
                if (rd_en && (32'(addr_q) == 32'(num_q))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave on the edge that accepts the final word.
                if ((vld_q == '0) &&
                    (((fcnt == '0) && !dval_q) ||
                     ((fcnt == CNT_W'(1)) && pop))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: next slice of the head, or slice 0 of the
    // following entry, is loaded on the accepting edge.
    always_comb begin
        dval_d  = dval_q;
        ddata_d = ddata_q;
        slice_d = slice_q;
        if (hs) begin
            if (!last_sl) begin
                slice_d = slice_q + 1'b1;
                ddata_d = head[int'(slice_d)*DDR_W +: DDR_W];
            end else if (fcnt >= CNT_W'(2)) begin
                slice_d = '0;
                ddata_d = nxt[int'(slice_d)*DDR_W +: DDR_W];
            end else begin
                slice_d = '0;
                dval_d  = 1'b0;
            end
        end else if (!dval_q && (fcnt != '0)) begin
            slice_d = '0;
            dval_d  = 1'b1;
            ddata_d = head[int'(slice_d)*DDR_W +: DDR_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            type_q  <= 1'b0;
            num_q   <= '0;
            pe_q    <= '0;
            vld_q   <= '0;
            slice_q <= '0;
            dval_q  <= 1'b0;
            ddata_q <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= (vld_q << 1) | RD_LAT'(rd_en);
            dval_q  <= dval_d;
            ddata_q <= ddata_d;
            slice_q <= slice_d;
            if ((state_q == IDLE) && start) begin
                type_q  <= conf_trans_type;
                num_q   <= conf_trans_num;
                pe_q    <= conf_pe_sel;
                addr_q  <= '0;
                slice_q <= '0;
            end else if (rd_en) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign done         = (state_q == IDLE);
    assign abuf_rd_pe   = pe_q;
    assign abuf_rd_addr = addr_q;
    assign abuf_rd_en   = rd_en;
    assign ddr_data     = ddata_q;
    assign ddr_valid    = dval_q;

endmodule

// File: tb/tb_abuf2ddr.sv
// tb_abuf2ddr: directed bench for abuf2ddr with a one-cycle buffer
// model; each task drives one scenario and checks its own results.
module tb_abuf2ddr;
    import abuf2ddr_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         done;
    logic         conf_trans_type = 1'b0;
    logic [7:0]   conf_trans_num = 8'd0;
    logic [4:0]   conf_pe_sel = 5'd3;
    logic [4:0]   abuf_rd_pe;
    logic [7:0]   abuf_rd_addr;
    logic         abuf_rd_en;
    logic [63:0]  abuf_rd_data = '0;
    logic [127:0] abuf_rd_tail = '0;
    logic [63:0]  ddr_data;
    logic         ddr_valid;
    logic         ddr_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    abuf2ddr dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .done            (done),
        .conf_trans_type (conf_trans_type),
        .conf_trans_num  (conf_trans_num),
        .conf_pe_sel     (conf_pe_sel),
        .abuf_rd_pe      (abuf_rd_pe),
        .abuf_rd_addr    (abuf_rd_addr),
        .abuf_rd_en      (abuf_rd_en),
        .abuf_rd_data    (abuf_rd_data),
        .abuf_rd_tail    (abuf_rd_tail),
        .ddr_data        (ddr_data),
        .ddr_valid       (ddr_valid),
        .ddr_ready       (ddr_ready)
    );

    always #5 clk = ~clk;

    // PE 5 holds {4{i}} at address i; other PEs hold a marked pattern.
    function automatic logic [63:0] mem_data(input logic [4:0] pe,
                                             input logic [7:0] a);
        logic [15:0] h;
        h = (pe == 5'd5) ? {8'h00, a} : {8'hE0, a};
        return {h, h, h, h};
    endfunction

    function automatic logic [127:0] mem_tail(input logic [7:0] a);
        if (a == 8'd0) return 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        return {16{a}};
    endfunction

    always @(posedge clk) begin
        if (abuf_rd_en) begin
            abuf_rd_data <= mem_data(abuf_rd_pe, abuf_rd_addr);
            abuf_rd_tail <= mem_tail(abuf_rd_addr);
        end
    end

    function automatic logic [63:0] exp_data(input int i);
        logic [15:0] h;
        h = 16'(i);
        return {h, h, h, h};
    endfunction

    task automatic do_start(input logic t, input logic [7:0] n,
                            input logic [4:0] p);
        @(posedge clk); #1;
        conf_trans_type = t;
        conf_trans_num  = n;
        conf_pe_sel     = p;
        start           = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (done !== 1'b1 || ddr_valid !== 1'b0 || ddr_data !== 64'd0 ||
            abuf_rd_en !== 1'b0 || abuf_rd_addr !== 8'd0 ||
            abuf_rd_pe !== 5'd0) begin
            failures++;
            $display("FAIL reset_values: done=%b valid=%b data=%h en=%b addr=%h pe=%h",
                     done, ddr_valid, ddr_data, abuf_rd_en, abuf_rd_addr,
                     abuf_rd_pe);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || abuf_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: done=%b en=%b exp 1 0",
                     done, abuf_rd_en);
        end
    endtask

    task automatic test_data_full_rate();
        int cnt = 0;
        ddr_ready = 1'b1;
        do_start(1'b0, 8'd7, 5'd5);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (abuf_rd_pe !== 5'd5) begin
                    failures++;
                    $display("FAIL full_rd_pe: got %0d exp 5", abuf_rd_pe);
                end
            end
            if (k == 2) begin
                checks++;
                if (ddr_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL full_early_valid: valid=%b exp 0", ddr_valid);
                end
            end
            if (ddr_valid === 1'b1) begin
                checks++;
                if (k != 3 + cnt || ddr_data !== exp_data(cnt)) begin
                    failures++;
                    $display("FAIL full_word%0d: got %h at k=%0d exp %h at k=%0d",
                             cnt, ddr_data, k, exp_data(cnt), 3 + cnt);
                end
                cnt++;
            end
            if (k == 10 || k == 11) begin
                checks++;
                if (done !== (k == 11)) begin
                    failures++;
                    $display("FAIL full_done k=%0d: got %b exp %b",
                             k, done, (k == 11));
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (cnt != 8) begin
            failures++;
            $display("FAIL full_count: got %0d exp 8", cnt);
        end
    endtask

    task automatic test_tail();
        int nv = 0;
        ddr_ready = 1'b1;
        do_start(1'b1, 8'd0, 5'd5);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ddr_valid === 1'b1) nv++;
            if (k == 3) begin
                checks++;
                if (ddr_valid !== 1'b1 || ddr_data !== 64'hFEDCBA9876543210) begin
                    failures++;
                    $display("FAIL tail_word0: valid=%b got %h exp FEDCBA9876543210",
                             ddr_valid, ddr_data);
                end
            end
            if (k == 4) begin
                checks++;
                if (ddr_valid !== 1'b1 || ddr_data !== 64'h0123456789ABCDEF ||
                    done !== 1'b0) begin
                    failures++;
                    $display("FAIL tail_word1: valid=%b done=%b got %h exp 0123456789ABCDEF",
                             ddr_valid, done, ddr_data);
                end
            end
            if (k == 5) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("FAIL tail_done: got %b exp 1", done);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (nv != 2) begin
            failures++;
            $display("FAIL tail_count: got %0d words exp 2", nv);
        end
    endtask

    task automatic test_backpressure();
        int cnt = 0;
        int issued = 0;
        int k = 0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [63:0] pd = '0;
        ddr_ready = 1'b0;
        do_start(1'b0, 8'd15, 5'd5);
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (pv && !pr) begin
                checks++;
                if (ddr_valid !== 1'b1 || ddr_data !== pd) begin
                    failures++;
                    $display("FAIL bp_stable: valid=%b data=%h exp 1 %h",
                             ddr_valid, ddr_data, pd);
                end
            end
            checks++;
            if (issued + int'(abuf_rd_en) - cnt > 4) begin
                failures++;
                $display("FAIL bp_credit: outstanding=%0d exp <=4",
                         issued + int'(abuf_rd_en) - cnt);
            end
            issued += int'(abuf_rd_en);
            if (ddr_valid === 1'b1 && ddr_ready === 1'b1) begin
                checks++;
                if (ddr_data !== exp_data(cnt)) begin
                    failures++;
                    $display("FAIL bp_word%0d: got %h exp %h",
                             cnt, ddr_data, exp_data(cnt));
                end
                cnt++;
            end
            pv = ddr_valid;
            pr = ddr_ready;
            pd = ddr_data;
            if (done === 1'b1 && cnt == 16) break;
            @(posedge clk); #1;
            ddr_ready = ($urandom_range(0, 9) < 3);
        end
        checks++;
        if (cnt != 16 || done !== 1'b1) begin
            failures++;
            $display("FAIL bp_complete: words=%0d done=%b exp 16 1", cnt, done);
        end
        checks++;
        if (issued != 16) begin
            failures++;
            $display("FAIL bp_reads: got %0d exp 16", issued);
        end
    endtask

    task automatic test_stall();
        int issued = 0;
        int cnt = 0;
        ddr_ready = 1'b0;
        do_start(1'b0, 8'd7, 5'd5);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            issued += int'(abuf_rd_en);
            if (k == 19) begin
                checks++;
                if (abuf_rd_en !== 1'b0 || ddr_valid !== 1'b1 ||
                    ddr_data !== exp_data(0)) begin
                    failures++;
                    $display("FAIL stall_hold: en=%b valid=%b data=%h exp 0 1 %h",
                             abuf_rd_en, ddr_valid, ddr_data, exp_data(0));
                end
            end
            if (k < 19) begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (issued != 4) begin
            failures++;
            $display("FAIL stall_reads: got %0d exp 4", issued);
        end
        @(posedge clk); #1;
        ddr_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            issued += int'(abuf_rd_en);
            if (ddr_valid === 1'b1) begin
                checks++;
                if (ddr_data !== exp_data(cnt)) begin
                    failures++;
                    $display("FAIL stall_word%0d: got %h exp %h",
                             cnt, ddr_data, exp_data(cnt));
                end
                cnt++;
            end
            if (done === 1'b1) break;
            @(posedge clk); #1;
        end
        checks++;
        if (cnt != 8 || issued != 8 || done !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: words=%0d reads=%0d done=%b exp 8 8 1",
                     cnt, issued, done);
        end
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        ddr_ready = 1'b1;
        do_start(1'b0, 8'd15, 5'd5);
        repeat (6) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (done !== 1'b1 || ddr_valid !== 1'b0 || abuf_rd_en !== 1'b0 ||
            ddr_data !== 64'd0 || abuf_rd_addr !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset: done=%b valid=%b en=%b data=%h addr=%h exp 1 0 0 0 0",
                     done, ddr_valid, abuf_rd_en, ddr_data, abuf_rd_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        do_start(1'b0, 8'd2, 5'd5);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (abuf_rd_en !== 1'b1 || abuf_rd_addr !== 8'd0) begin
                    failures++;
                    $display("FAIL mid_restart_addr: en=%b addr=%0d exp 1 0",
                             abuf_rd_en, abuf_rd_addr);
                end
            end
            if (ddr_valid === 1'b1) begin
                checks++;
                if (ddr_data !== exp_data(cnt)) begin
                    failures++;
                    $display("FAIL mid_word%0d: got %h exp %h",
                             cnt, ddr_data, exp_data(cnt));
                end
                cnt++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (cnt != 3 || done !== 1'b1) begin
            failures++;
            $display("FAIL mid_complete: words=%0d done=%b exp 3 1", cnt, done);
        end
    endtask

    task automatic test_ignored_start();
        int cnt = 0;
        ddr_ready = 1'b1;
        do_start(1'b0, 8'd7, 5'd5);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 3 || k == 12) begin
                checks++;
                if (abuf_rd_pe !== 5'd5) begin
                    failures++;
                    $display("FAIL ign_rd_pe k=%0d: got %0d exp 5", k, abuf_rd_pe);
                end
            end
            if (ddr_valid === 1'b1) begin
                checks++;
                if (k != 3 + cnt || ddr_data !== exp_data(cnt)) begin
                    failures++;
                    $display("FAIL ign_word%0d: got %h at k=%0d exp %h at k=%0d",
                             cnt, ddr_data, k, exp_data(cnt), 3 + cnt);
                end
                cnt++;
            end
            if (k == 11) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("FAIL ign_done: got %b exp 1", done);
                end
            end
            @(posedge clk); #1;
            if (k == 1) begin
                start           = 1'b1;
                conf_pe_sel     = 5'd9;
                conf_trans_num  = 8'd2;
                conf_trans_type = 1'b1;
            end
            if (k == 2) start = 1'b0;
        end
        checks++;
        if (cnt != 8) begin
            failures++;
            $display("FAIL ign_count: got %0d exp 8", cnt);
        end
    endtask

    task automatic test_start_at_end();
        ddr_ready = 1'b1;
        do_start(1'b0, 8'd1, 5'd5);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 4) begin
                checks++;
                if (ddr_valid !== 1'b1 || ddr_data !== exp_data(1) ||
                    done !== 1'b0) begin
                    failures++;
                    $display("FAIL end_last_word: valid=%b done=%b data=%h exp 1 0 %h",
                             ddr_valid, done, ddr_data, exp_data(1));
                end
            end
            if (k >= 5) begin
                checks++;
                if (done !== 1'b1 || abuf_rd_en !== 1'b0 || ddr_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL end_start_ignored k=%0d: done=%b en=%b valid=%b exp 1 0 0",
                             k, done, abuf_rd_en, ddr_valid);
                end
            end
            @(posedge clk); #1;
            if (k == 3) start = 1'b1;
            if (k == 4) start = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_data_full_rate();
        test_tail();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_ignored_start();
        test_start_at_end();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
